// File: rtl/definitions_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | definitions_pkg : shared types, default constants and helpers for the       |
// |                   serial edge-detection chip.                               |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
package definitions_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    typedef logic [7:0] pixel_t;

    localparam int c_CLKS_PER_BIT = 32;
    localparam int c_IMG_WIDTH    = 512;
    localparam int c_THRESHOLD    = 32;

    // Magnitude of a 9-bit difference; the borrow bit selects the negation.
    function automatic pixel_t abs_diff(input pixel_t a, input pixel_t b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[8] ? pixel_t'(~diff[7:0] + 8'd1) : diff[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_uart_tx : 8N1 UART serialiser, LSB first, idle high.                   |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module edge_uart_tx
    import definitions_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_start,
    input  pixel_t i_data,
    output logic   o_busy,
    output logic   o_done,
    output logic   o_tx
);

    localparam int                  c_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]  c_BIT_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t        state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    pixel_t             data_q, data_d;
    logic               tx_q, tx_d;
    logic               w_bit_end;

    assign w_bit_end = (cnt_q == c_BIT_M1);
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == STOP) && w_bit_end;
    assign o_tx      = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A start on the last stop-bit cycle chains the next frame with no idle gap.
        if (i_start && ((state_q == IDLE) || o_done)) begin
            state_d = START;
            cnt_d   = '0;
            data_d  = i_data;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/edge_chip_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_chip_top : UART-in / UART-out horizontal edge detector.                |
// | Define EDGE_MAG_OUT_EN to return gradient magnitude instead of 00/FF.       |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module edge_chip_top
    import definitions_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
    parameter int IMG_WIDTH    = c_IMG_WIDTH,
    parameter int THRESHOLD    = c_THRESHOLD
) (
    input  logic clk,
    input  logic rstN,
    input  logic rx,
    output logic tx
);

    localparam int                  c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]  c_BIT_M1  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int                  c_COL_W   = $clog2(IMG_WIDTH);
    localparam logic [c_COL_W-1:0]  c_COL_MAX = c_COL_W'(IMG_WIDTH - 1);

    logic               rx_meta_q, rx_sync_q;
    uart_state_t        rx_state_q, rx_state_d;
    logic [c_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    pixel_t             rx_shift_q, rx_shift_d;
    logic               rx_valid_q, rx_valid_d;
    pixel_t             rx_data_q, rx_data_d;

    pixel_t             prev_pix_q, prev_pix_d;
    logic [c_COL_W-1:0] col_q, col_d;
    logic               res_valid_q, res_valid_d;
    pixel_t             res_q, res_d;
    logic               pend_valid_q, pend_valid_d;
    pixel_t             pend_q, pend_d;

    pixel_t             w_grad;
    pixel_t             w_res;
    logic               w_tx_ready;
    logic               w_tx_start;
    pixel_t             w_tx_data;
    logic               w_tx_busy;
    logic               w_tx_done;

    // Receiver: sampling points are mid-bit, referenced to the synchronised falling edge.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        case (rx_state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = START;
                    rx_cnt_d   = '0;
                end
            end
            START: begin
                if (rx_cnt_q == c_HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + c_CNT_W'(1);
                end
            end
            DATA: begin
                if (rx_cnt_q == c_BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + c_CNT_W'(1);
                end
            end
            STOP: begin
                if (rx_cnt_q == c_BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = IDLE;
                    if (rx_sync_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + c_CNT_W'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    assign w_grad = abs_diff(rx_data_q, prev_pix_q);

`ifdef EDGE_MAG_OUT_EN
    assign w_res = (col_q == '0) ? 8'h00 : w_grad;
`else
    assign w_res = (col_q == '0) ? 8'h00 :
                   ((int'(w_grad) >= THRESHOLD) ? 8'hFF : 8'h00);
`endif

    always_comb begin
        res_valid_d = rx_valid_q;
        res_d       = res_q;
        prev_pix_d  = prev_pix_q;
        col_d       = col_q;
        if (rx_valid_q) begin
            res_d      = w_res;
            prev_pix_d = rx_data_q;
            col_d      = (col_q == c_COL_MAX) ? '0 : col_q + c_COL_W'(1);
        end
    end

    // A fresh result takes the transmitter ahead of a parked one; the parked byte waits.
    assign w_tx_ready = !w_tx_busy || w_tx_done;

    always_comb begin
        w_tx_start   = 1'b0;
        w_tx_data    = res_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        if (res_valid_q) begin
            if (w_tx_ready) begin
                w_tx_start = 1'b1;
                w_tx_data  = res_q;
            end else begin
                pend_valid_d = 1'b1;
                pend_d       = res_q;
            end
        end else if (pend_valid_q && w_tx_ready) begin
            w_tx_start   = 1'b1;
            w_tx_data    = pend_q;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            prev_pix_q   <= '0;
            col_q        <= '0;
            res_valid_q  <= 1'b0;
            res_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            prev_pix_q   <= prev_pix_d;
            col_q        <= col_d;
            res_valid_q  <= res_valid_d;
            res_q        <= res_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    edge_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rstN),
        .i_start(w_tx_start),
        .i_data (w_tx_data),
        .o_busy (w_tx_busy),
        .o_done (w_tx_done),
        .o_tx   (tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_edge_chip_top.sv
`default_nettype none
// Scoreboard bench for edge_chip_top: a frame-level pixel model feeds an expected-reply
// queue, and an independent UART monitor decodes tx and compares against it.
module tb_edge_chip_top;

    localparam int CLKS   = 16;
    localparam int WIDTH  = 64;
    localparam int THRESH = 32;
    localparam int HALF   = CLKS / 2;
    localparam int N_RAND = 120;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    logic rx   = 1'b1;
    logic tx;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int m_prev = 0;
    int m_col  = 0;

    edge_chip_top #(
        .CLKS_PER_BIT(CLKS),
        .IMG_WIDTH   (WIDTH),
        .THRESHOLD   (THRESH)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .rx  (rx),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: absolute difference with integers, column count modulo the row width.
    function automatic logic [7:0] model_pixel(input int pix);
        int g;
        logic [7:0] r;
        g = (pix > m_prev) ? pix - m_prev : m_prev - pix;
        if (m_col == 0) begin
            r = 8'h00;
        end else begin
`ifdef EDGE_MAG_OUT_EN
            r = 8'(g);
`else
            r = (g >= THRESH) ? 8'hFF : 8'h00;
`endif
        end
        m_prev = pix;
        m_col  = (m_col + 1) % WIDTH;
        return r;
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good_stop);
        if (good_stop) exp_q.push_back(model_pixel(int'(b)));
        @(negedge clk);
        hold(1'b0, CLKS);
        for (int i = 0; i < 8; i++) hold(b[i], CLKS);
        if (good_stop) begin
            hold(1'b1, CLKS);
        end else begin
            hold(1'b0, (CLKS * 3) / 4);
            hold(1'b1, CLKS);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 16 * CLKS) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_replies", exp_q.size(), 32'd0);
        repeat (2 * CLKS) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b1;
        exp_q.delete();
        m_prev = 0;
        m_col  = 0;
        repeat (3) @(negedge clk);
        rstN = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_neg(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rstN) ab = 1'b1;
        end
    endtask

    initial begin : monitor
        logic [7:0] d;
        logic [7:0] e;
        logic sb;
        logic eb;
        bit ab;
        forever begin
            @(negedge clk);
            if (!rstN && tx === 1'b0) begin
                ab = 1'b0;
                wait_neg(HALF, ab);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    wait_neg(CLKS, ab);
                    d[i] = tx;
                end
                wait_neg(CLKS, ab);
                eb = tx;
                if (!ab) begin
                    check("reply_start_stop_bits", {30'd0, sb, eb}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_reply: got %02h required no frame", d);
                    end else begin
                        e = exp_q.pop_front();
                        check("reply_byte", {24'd0, d}, {24'd0, e});
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        int v;
        bit good;

        rstN = 1'b1;
        rx   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("tx_high_in_reset", {31'd0, tx}, 32'd1);
        end
        rstN = 1'b0;
        repeat (4 * CLKS) @(negedge clk);
        check("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        // First pixel, above-threshold, below-threshold and exact-threshold gradients.
        send_frame(8'h10, 1'b1);
        send_frame(8'h40, 1'b1);
        send_frame(8'h50, 1'b1);
        send_frame(8'h60, 1'b1);
        send_frame(8'h40, 1'b1);
        drain();

        // Full row plus one: the extra byte lands in column 0 of the next row.
        do_reset();
        for (int i = 0; i < WIDTH + 1; i++) send_frame((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1);
        drain();

        // Start-bit glitch and framing error must leave no reply and no state change.
        hold(1'b0, CLKS / 4);
        hold(1'b1, 2 * CLKS);
        send_frame(8'hC3, 1'b0);
        hold(1'b1, CLKS);
        send_frame(8'h7E, 1'b1);
        drain();

        for (int k = 0; k < N_RAND; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                v = int'($urandom_range(255, 0));
            end else begin
                v = m_prev + (($urandom_range(1, 0) == 1) ? 1 : -1)
                           * (THRESH - 1 + int'($urandom_range(2, 0)));
                if (v < 0) v = 0;
                if (v > 255) v = 255;
            end
            good = ($urandom_range(15, 0) != 0);
            send_frame(8'(v), good);
            repeat ($urandom_range(CLKS, 0)) @(negedge clk);
        end
        drain();

        // Reset in the middle of an outgoing frame.
        send_frame(8'hA5, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 4 * CLKS) begin
            @(negedge clk);
            n++;
        end
        check("tx_frame_started", {31'd0, tx}, 32'd0);
        repeat (3 * CLKS) @(negedge clk);
        #2;
        rstN = 1'b1;
        exp_q.delete();
        m_prev = 0;
        m_col  = 0;
        #1;
        check("tx_async_high_on_reset", {31'd0, tx}, 32'd1);
        repeat (4) @(negedge clk);
        check("tx_high_during_reset", {31'd0, tx}, 32'd1);
        rstN = 1'b0;
        repeat (12 * CLKS) @(negedge clk);
        send_frame(8'h10, 1'b1);
        send_frame(8'h25, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
